// File: rtl/impressora_parametrizada.sv
// Sequential binary-to-seven-segment printer. Iterative double-dabble (one bit per clock)
// with leading-zero blanking, signed minus display and overflow indication.
module impressora_parametrizada #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      valor,
  input  logic                  inicio,
  input  logic                  apagar_zeros,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  estouro
);

  // BCD nibbles sized for any WIDTH-bit magnitude: ceil(WIDTH*0.302)+1.
  localparam int NIB   = (WIDTH * 302 + 999) / 1000 + 1;
  localparam int BW    = 4 * NIB;
  localparam int PW    = (NIB > DIGITS) ? NIB : DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int LW    = (WIDTH > 32) ? WIDTH + 1 : 33;

  localparam logic [LW-1:0] LIM_POS = LW'(10 ** DIGITS - 1);
  localparam logic [LW-1:0] LIM_NEG = LW'(10 ** (DIGITS - 1) - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_ENC  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [1:0]          state_q,   state_d;
  logic [WIDTH-1:0]    mag_q,     mag_d;
  logic [BW-1:0]       bcd_q,     bcd_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                neg_q,     neg_d;
  logic                blank_q,   blank_d;
  logic                ovf_q,     ovf_d;
  logic [7*DIGITS-1:0] hex_q,     hex_d;
  logic                ocupado_q, ocupado_d;
  logic                pronto_q,  pronto_d;
  logic                estouro_q, estouro_d;

  logic [WIDTH-1:0]    mag_in;
  logic                neg_in;
  logic [BW-1:0]       bcd_adj;
  logic [4*PW-1:0]     bcd_pad;
  logic [7*DIGITS-1:0] hex_enc;
  logic                seen_nz;
  logic [3:0]          nib;
  logic [6:0]          seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Magnitude held in WIDTH bits so the most-negative value negates exactly.
  always_comb begin
    neg_in = (SIGNED != 0) && valor[WIDTH-1];
    mag_in = neg_in ? (~valor + WIDTH'(1)) : valor;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < NIB; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  // Scan from the top digit down so blanking stops at the first nonzero digit.
  always_comb begin
    bcd_pad          = '0;
    bcd_pad[BW-1:0]  = bcd_q;
    hex_enc          = '1;
    seen_nz          = 1'b0;
    nib              = 4'd0;
    seg              = SEG_BLANK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd_pad[4*i +: 4];
      if (ovf_q || (neg_q && i == DIGITS - 1))               seg = SEG_DASH;
      else if (blank_q && !seen_nz && nib == 4'd0 && i != 0) seg = SEG_BLANK;
      else                                                   seg = seg7(nib);
      if (nib != 4'd0) seen_nz = 1'b1;
      hex_enc[7*i +: 7] = seg;
    end
  end

  // NOTE: every *_d starts from its *_q (or a pulse default) so no path leaves a
  // combinational output unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    hex_d     = hex_q;
    ocupado_d = ocupado_q;
    pronto_d  = 1'b0;
    estouro_d = estouro_q;
    case (state_q)
      S_IDLE: begin
        if (inicio) begin
          mag_d     = mag_in;
          neg_d     = neg_in;
          blank_d   = apagar_zeros;
          ovf_d     = LW'(mag_in) > (neg_in ? LIM_NEG : LIM_POS);
          bcd_d     = '0;
          cnt_d     = '0;
          ocupado_d = 1'b1;
          state_d   = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_ENC;
      end
      S_ENC: begin
        hex_d     = hex_enc;
        estouro_d = ovf_q;
        pronto_d  = 1'b1;
        ocupado_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      blank_q   <= 1'b0;
      ovf_q     <= 1'b0;
      hex_q     <= '1;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      estouro_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
      hex_q     <= hex_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
      estouro_q <= estouro_d;
    end
  end

  assign hex     = hex_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
  assign estouro = estouro_q;

endmodule

// File: tb/tb_impressora_parametrizada.sv
// Scoreboard bench: an unsigned and a signed printer share stimulus; expectations come
// from a divide/modulo decimal model and are checked when each instance pulses pronto.
module tb_impressora_parametrizada;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] valor = '0;
  logic        inicio = 1'b0;
  logic        apagar_zeros = 1'b0;

  logic [27:0] hex_u, hex_s;
  logic        ocupado_u, pronto_u, estouro_u;
  logic        ocupado_s, pronto_s, estouro_s;

  impressora_parametrizada #(.WIDTH(16), .DIGITS(4), .SIGNED(0)) dut_u (
    .clock(clock), .reset(reset), .valor(valor), .inicio(inicio),
    .apagar_zeros(apagar_zeros), .hex(hex_u), .ocupado(ocupado_u),
    .pronto(pronto_u), .estouro(estouro_u));

  impressora_parametrizada #(.WIDTH(16), .DIGITS(4), .SIGNED(1)) dut_s (
    .clock(clock), .reset(reset), .valor(valor), .inicio(inicio),
    .apagar_zeros(apagar_zeros), .hex(hex_s), .ocupado(ocupado_s),
    .pronto(pronto_s), .estouro(estouro_s));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  localparam logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  typedef struct {
    logic [27:0] hex;
    logic        ovf;
    int          start;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];
  int   done_u = 0, done_s = 0, pronto_cyc_u = 0;
  int   n_conv = 0;
  int   n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [15:0] v, input bit blank, input bit sgn,
                                 input int start);
    exp_t m;
    bit   neg;
    int   mag, lim, p;
    neg     = sgn && v[15];
    mag     = neg ? (65536 - int'(v)) : int'(v);
    lim     = neg ? 999 : 9999;
    m.ovf   = (mag > lim);
    m.start = start;
    m.hex   = '1;
    for (int i = 0; i < 4; i++) begin
      p = 10 ** i;
      if (m.ovf || (neg && i == 3))        m.hex[7*i +: 7] = DASH;
      else if (blank && i > 0 && mag < p)  m.hex[7*i +: 7] = BLANK;
      else                                 m.hex[7*i +: 7] = SEG[(mag / p) % 10];
    end
    return m;
  endfunction

  always @(negedge clock) begin : mon_u
    exp_t e;
    if (pronto_u) begin
      done_u++;
      pronto_cyc_u = cyc;
      if (q_u.size() == 0) check("unexpected_pronto_u", 1, 0);
      else begin
        e = q_u.pop_front();
        check("hex_u", hex_u, e.hex);
        check("estouro_u", estouro_u, e.ovf);
        check("latency_u", cyc - e.start, 17);
        check("ocupado_low_u", ocupado_u, 0);
      end
    end
  end

  always @(negedge clock) begin : mon_s
    exp_t e;
    if (pronto_s) begin
      done_s++;
      if (q_s.size() == 0) check("unexpected_pronto_s", 1, 0);
      else begin
        e = q_s.pop_front();
        check("hex_s", hex_s, e.hex);
        check("estouro_s", estouro_s, e.ovf);
        check("latency_s", cyc - e.start, 17);
      end
    end
  end

  task automatic push_exp(input logic [15:0] v, input bit blank, input int start);
    q_u.push_back(model(v, blank, 1'b0, start));
    q_s.push_back(model(v, blank, 1'b1, start));
  endtask

  task automatic start(input logic [15:0] v, input bit blank);
    @(negedge clock);
    valor        = v;
    apagar_zeros = blank;
    inicio       = 1'b1;
    push_exp(v, blank, cyc + 1);
    @(negedge clock);
    inicio       = 1'b0;
    valor        = 16'($urandom);
    apagar_zeros = 1'($urandom);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while ((done_u < target || done_s < target) && k < 60) begin
      @(negedge clock);
      k++;
    end
    check("done_count_u", done_u, target);
    check("done_count_s", done_s, target);
  endtask

  task automatic convert(input logic [15:0] v, input bit blank);
    n_conv++;
    start(v, blank);
    wait_done(n_conv);
  endtask

  task automatic check_reset_outputs();
    check("rst_hex_u", hex_u, 28'hFFFFFFF);
    check("rst_hex_s", hex_s, 28'hFFFFFFF);
    check("rst_ocupado", {ocupado_u, ocupado_s}, 2'b00);
    check("rst_pronto", {pronto_u, pronto_s}, 2'b00);
    check("rst_estouro", {estouro_u, estouro_s}, 2'b00);
  endtask

  initial begin
    int first_pronto;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_outputs();

    convert(16'd1234, 1'b0);
    check("hex_1234_literal", hex_u, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    convert(16'd9999, 1'b0);
    convert(16'd10000, 1'b0);
    convert(16'd65535, 1'b0);
    convert(16'd5, 1'b1);
    convert(16'd0, 1'b1);
    convert(16'd5, 1'b0);
    convert(16'hFF85, 1'b0);
    convert(16'hFC18, 1'b0);
    convert(16'h8000, 1'b0);
    convert(16'h270F, 1'b0);
    convert(16'hFFFB, 1'b1);
    convert(16'd407, 1'b1);
    repeat (6) convert(16'($urandom), 1'($urandom));

    // inicio pulsed in the middle of a conversion must be ignored
    n_conv++;
    start(16'd300, 1'b0);
    repeat (5) @(negedge clock);
    inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    wait_done(n_conv);
    repeat (25) @(negedge clock);
    check("mid_conv_single_pronto", done_u, n_conv);

    // inicio held through pronto: second conversion accepted at the next edge
    @(negedge clock);
    valor        = 16'd4321;
    apagar_zeros = 1'b0;
    inicio       = 1'b1;
    push_exp(16'd4321, 1'b0, cyc + 1);
    n_conv++;
    @(negedge clock);
    valor = 16'hFF9C;
    wait_done(n_conv);
    first_pronto = pronto_cyc_u;
    push_exp(16'hFF9C, 1'b0, first_pronto + 1);
    n_conv++;
    @(negedge clock);
    inicio = 1'b0;
    wait_done(n_conv);
    check("back_to_back_gap", pronto_cyc_u - first_pronto, 18);

    // reset during a conversion aborts it without pronto
    convert(16'd65535, 1'b0);
    start(16'd1234, 1'b0);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    q_u.delete();
    q_s.delete();
    check_reset_outputs();
    repeat (25) @(negedge clock);
    check("aborted_no_pronto", done_u, n_conv);
    convert(16'd4321, 1'b0);
    convert(16'hFF85, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/impressora_parametrizada.md
# impressora_parametrizada

Sequential, parametrised binary-to-seven-segment printer: converts a WIDTH-bit value (unsigned or two's-complement) into DIGITS active-low seven-segment codes. Conversion is iterative double-dabble (shift-add-3), one input bit per clock, behind a start/busy/done handshake. The block adds optional leading-zero blanking, a signed minus mode and an explicit overflow flag. It sits between arithmetic result registers and the board HEX displays, and replaces the fixed 16-bit/4-digit combinational printer.

## Interface
- WIDTH, 16, input value width (≥ 4)
- DIGITS, 4, number of displayed digits (1–8)
- SIGNED, 0, 1 = `valor` is two's-complement; leftmost digit reserved for sign
- clock  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- valor  input  WIDTH  value to print, sampled with `inicio`
- inicio  input  1  start request, sampled only in IDLE
- apagar_zeros  input  1  leading-zero blanking enable, sampled with `inicio`
- hex  output  7*DIGITS  registered segment codes, digit i at bits [7i+6:7i], digit 0 = units; active-low, bit 6 = segment g
- ocupado  output  1  conversion in progress
- pronto  output  1  one-cycle pulse when `hex` is updated
- estouro  output  1  last conversion exceeded display range; held until next update

## Operation
- Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, dash/minus=0111111.
- States: IDLE, CONV, ENC.
- IDLE: on `inicio`=1, latch magnitude (SIGNED and MSB set: two's-complement negate, held in WIDTH bits so the most-negative value is exact), sign flag and `apagar_zeros`; clear BCD accumulator and bit counter; go to CONV.
- CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, magnitude} left by one. The BCD accumulator holds enough nibbles for any WIDTH-bit magnitude (ceil(WIDTH·0.302)+1), independent of DIGITS. After WIDTH shifts, go to ENC.
- Overflow limit: 10^DIGITS−1 for unsigned values and non-negative signed values; 10^(DIGITS−1)−1 for negative values. Compare the latched binary magnitude against the limit. Overflow does not shorten the conversion.
- ENC: register `hex`, `estouro`; pulse `pronto`; return to IDLE.
  - Overflow: every digit is a dash and `estouro`=1.
  - Otherwise `estouro`=0. Magnitude digits occupy digits 0..DIGITS−1, or 0..DIGITS−2 when negative. Negative values put a minus in digit DIGITS−1. Non-negative values in SIGNED mode use all digits.
  - Blanking: leading zero digits above the most significant nonzero digit become blank. Digit 0 is never blanked. The minus position is unaffected by blanking.
- `inicio` while CONV or ENC is ignored; there is no queuing.

## Timing
- Reset (sampled at a rising edge): state IDLE; `hex` all blank (1111111); `ocupado`=0, `pronto`=0, `estouro`=0. Reset in any state aborts the conversion with no `pronto`.
- Edge E0 samples `inicio` → `ocupado`=1 from E0.
- Edges E1..E_WIDTH perform the shifts.
- Edge E_(WIDTH+1): `hex`/`estouro` valid, `pronto`=1 for exactly one cycle, `ocupado`=0.
- Latency is WIDTH+1 cycles from the edge that samples `inicio` to `pronto`, fixed for all values.
- Throughput: `inicio` held high during the `pronto` cycle is accepted at the next edge. Back-to-back period is WIDTH+2 cycles.
- `hex` and `estouro` change only in ENC or on reset. `valor` may change freely after E0.

## Test plan
- WIDTH=16, DIGITS=4: reset → `hex`=all 1111111 and flags 0. Then `valor`=1234 with `inicio` pulse → `pronto` 17 cycles later; digits 3..0 = 1111001, 0100100, 0110000, 0011001; `estouro`=0.
- Range boundary: 9999 → all four digits 0010000, `estouro`=0. 10000 and 65535 → all digits 0111111, `estouro`=1.
- Blanking: `apagar_zeros`=1, `valor`=5 → digits 3..1 blank, digit 0 = 0010010. `valor`=0 → digit 0 = 1000000, the others blank. `apagar_zeros`=0, `valor`=5 → 1000000, 1000000, 1000000, 0010010.
- SIGNED=1: 16'hFF85 (−123) → 0111111, 1111001, 0100100, 0110000.
  - 16'hFC18 (−1000) → all dashes, `estouro`=1.
  - 16'h8000 → all dashes, `estouro`=1.
  - 16'h270F (9999) → 9999 with `estouro`=0.
- Handshake: `inicio` pulsed mid-CONV → ignored, single `pronto`. `inicio` held high through `pronto` → second conversion starts and its `pronto` follows 18 cycles after the first.
- Reset asserted at cycle 8 of a conversion → outputs return to reset values, no `pronto`. A new `inicio` afterwards converts correctly.
